// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage and its environment: instruction
// memory port, hazard/redirect controls and the IF/ID pipeline outputs.
interface if_stage_if;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcPlus4;
  logic        ifid_valid;
  logic [31:0] fetchCount;

  // Fetch-stage side.
  modport master (
    output imemAddr, pc, ifid_instr, ifid_pcPlus4, ifid_valid, fetchCount,
    input  imemData, stall, branchTaken, branchTarget
  );

  // Environment side: memory, hazard unit, redirect source, decode.
  modport slave (
    input  imemAddr, pc, ifid_instr, ifid_pcPlus4, ifid_valid, fetchCount,
    output imemData, stall, branchTaken, branchTarget
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, asynchronous instruction-memory
// address, IF/ID pipeline register and a retired-fetch counter.
// Edge priority: reset > redirect > stall > normal fetch.
module if_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [31:0] startPC,
  if_stage_if.master  bus
);

  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;
  logic [31:0] count_r;

  logic [31:0] pc_next_s;
  logic [31:0] start_aligned_s;
  logic [31:0] target_aligned_s;

  // Word-align incoming addresses and form the sequential successor;
  // the add wraps modulo 2^32 so FFFFFFFC steps to 00000000.
  always_comb begin
    pc_next_s        = pc_r + 32'd4;
    start_aligned_s  = {startPC[31:2], 2'b00};
    target_aligned_s = {bus.branchTarget[31:2], 2'b00};
  end

  // PC, IF/ID register and fetch counter update with reset > redirect > stall > fetch.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      pc_r       <= start_aligned_s;
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
      count_r    <= 32'h0000_0000;
    end else if (bus.branchTaken) begin
      // Redirect discards the wrong-path instruction; the count is untouched.
      pc_r       <= target_aligned_s;
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
      count_r    <= count_r;
    end else if (bus.stall) begin
      pc_r       <= pc_r;
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
      count_r    <= count_r;
    end else begin
      pc_r       <= pc_next_s;
      instr_r    <= bus.imemData;
      pc_plus4_r <= pc_next_s;
      valid_r    <= 1'b1;
      count_r    <= count_r + 32'd1;
    end
  end

  // imemAddr is the only combinational output: memory reads the live PC.
  assign bus.imemAddr     = pc_r;
  assign bus.pc           = pc_r;
  assign bus.ifid_instr   = instr_r;
  assign bus.ifid_pcPlus4 = pc_plus4_r;
  assign bus.ifid_valid   = valid_r;
  assign bus.fetchCount   = count_r;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined processor. It holds the program counter, drives the asynchronous-read instruction memory, and loads the IF/ID pipeline register that feeds decode. It also accepts stall requests from hazard detection and branch redirects from the MEM stage, and keeps a retired-fetch counter for test visibility.

## Interface
Parameters:
- NOP_INSTR, 32'h00000000, bubble instruction written into IF/ID on reset and on flush.

Ports:
- CLK  input  1  processor clock; all state updates on rising edge.
- Reset_L  input  1  synchronous, active-low reset, sampled on rising edge of CLK.
- startPC  input  32  PC loaded on every reset edge; bits [1:0] forced to 00.
- stall  input  1  hazard-unit request to hold PC and IF/ID.
- branchTaken  input  1  MEM-stage redirect; flushes IF/ID.
- branchTarget  input  32  redirect address; bits [1:0] forced to 00.
- imemAddr  output  32  equals pc (combinational from the PC register).
- imemData  input  32  instruction at imemAddr, valid in the same cycle.
- pc  output  32  current PC register.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pcPlus4  output  32  IF/ID copy of fetch PC + 4.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetchCount  output  32  number of instructions latched into IF/ID with valid=1.

## Operation
- Per-edge priority: reset > branchTaken > stall > normal fetch.
- Reset (Reset_L=0 at edge):
  - pc <= {startPC[31:2],2'b00}.
  - ifid_instr <= NOP_INSTR, ifid_pcPlus4 <= 0, ifid_valid <= 0, fetchCount <= 0.
  - Held reset re-samples startPC each edge, so the value present at the last reset edge wins.
- Redirect (branchTaken=1):
  - pc <= {branchTarget[31:2],2'b00}.
  - IF/ID <= bubble (NOP_INSTR, pcPlus4 0, valid 0).
  - fetchCount unchanged.
  - Overrides a simultaneous stall.
- Stall (stall=1, branchTaken=0):
  - pc, all IF/ID fields and fetchCount hold.
  - imemAddr remains on the held pc.
- Normal fetch:
  - pc <= pc + 4.
  - ifid_instr <= imemData, ifid_pcPlus4 <= pc + 4, ifid_valid <= 1.
  - fetchCount <= fetchCount + 1.
- Arithmetic:
  - All adds are 32-bit modulo 2^32. pc 32'hFFFFFFFC fetches, then wraps to 32'h00000000.
  - fetchCount wraps from 32'hFFFFFFFF to 0.
- No internal FSM beyond the registers. The block is always fetching unless held in reset, stalled or redirected.

## Timing
- imemAddr = pc with zero latency. imemData must settle within the same cycle.
- Fetch latency: the instruction at address A is presented during cycle n and appears on ifid_instr after edge n+1.
- First fetch after reset release:
  - In the first cycle with Reset_L=1, imemAddr = startPC.
  - The instruction at startPC is in IF/ID one edge later.
- Stall cost: each stalled edge delays the stream by exactly one cycle; no instruction is lost or duplicated.
- Redirect cost:
  - The edge with branchTaken=1 loads target into pc and a bubble into IF/ID.
  - The target instruction appears in IF/ID one edge after that.
- Reset mid-operation: takes effect at the next edge regardless of stall or branchTaken; the in-flight IF/ID contents are discarded.
- All outputs are registered except imemAddr, which is a wire from pc.

## Test plan
- Reset/start: hold Reset_L=0 two edges with startPC=32'h60 (second edge startPC=32'hA0), release. Required: pc=32'hA0, ifid_valid=0, fetchCount=0, then ifid_instr=mem[0xA0] and ifid_pcPlus4=32'hA4 after one edge.
- Sequential fetch: memory words = address; run 5 edges from 0. Required:
  - ifid_instr sequence 0,4,8,C,10.
  - fetchCount=5.
  - pc=32'h14.
- Stall: assert stall for 3 edges at pc=32'h8. Required:
  - pc, ifid_instr (=4) and fetchCount held for 3 edges.
  - Fetch resumes with 8; no duplication.
- Branch with simultaneous stall: at pc=32'h10, assert branchTaken=1, stall=1, branchTarget=32'h42. Required:
  - pc=32'h40 and ifid_valid=0, fetchCount unchanged.
  - Next edge: ifid_instr=mem[0x40], ifid_pcPlus4=32'h44.
- Wrap-around: reset with startPC=32'hFFFFFFF8, run 3 edges. Required:
  - pc sequence FFFFFFFC, 00000000, 00000004.
  - ifid_pcPlus4 for the FFFFFFFC fetch = 0.
- Reset mid-stream: assert Reset_L=0 together with branchTaken=1 and startPC=32'h0. Required: pc=0, IF/ID bubble, fetchCount=0 (reset wins).
